bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Two-master, one-slave arbiter for the shared external memory bus in the multi-cycle/pipelined core.
- Master 0 is instruction fetch, which is read-only. Master 1 is the data path, i.e. the memory access stage bus outputs.
- Arbitrates, holds the bus stable until the slave acknowledges, returns read data with a one-cycle ready pulse, and aborts hung accesses with an error after a timeout.

Parameters:
- TIMEOUT_CYCLES, 64, max cycles the bus waits for bus_ack before aborting with error (>=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  fetch request; held high until m0_ready.
- m0_addr  in  32  fetch address; stable while m0_req.
- m0_ready  out  1  one-cycle completion pulse for master 0.
- m0_rdata  out  32  fetch data; valid while m0_ready.
- m0_err  out  1  timeout flag; valid while m0_ready.
- m1_re  in  1  data read request.
- m1_we  in  4  data byte write enables.
- m1_addr  in  32  data address.
- m1_wdata  in  32  data write value.
- m1_ready  out  1  one-cycle completion pulse for master 1.
- m1_rdata  out  32  load data; valid while m1_ready.
- m1_err  out  1  timeout flag; valid while m1_ready.
- bus_re  out  1  bus read strobe.
- bus_we  out  4  bus byte write strobes.
- bus_addr  out  32  bus address.
- bus_wdata  out  32  bus write data.
- bus_rdata  in  32  slave read data; valid with bus_ack.
- bus_ack  in  1  slave completion; one cycle.

Behaviour:
- Reset values:
  - State IDLE, last_grant=M0, timeout counter 0, latched request registers 0.
  - All outputs 0.
- Master 1 request: m1_req = m1_re | (|m1_we). Requests with both m1_re=0 and m1_we=0 are ignored.
- If m1_we!=0 and m1_re=1 together, the access is a write and bus_re=0.
- States: IDLE, BUSY_M0, BUSY_M1.
- IDLE:
  - A master is eligible if its request is high and its own ready is not high in the same cycle. This prevents regrant on the completion cycle.
  - Only one eligible master: grant it.
  - Both eligible: grant the master that is not last_grant (round-robin).
  - On grant: latch address, we, re and wdata; update last_grant; clear the counter; go to BUSY_x.
- BUSY_x:
  - Bus outputs are driven only from the latched registers. They are stable for the whole transaction and all 0 in IDLE.
  - Master 0 transactions always drive bus_re=1 and bus_we=0.
  - Counter increments each BUSY cycle.
  - bus_ack=1: on the next edge, mx_rdata<=bus_rdata (0 for writes), mx_err<=0, mx_ready<=1 for one cycle, state IDLE.
  - No ack while counter==TIMEOUT_CYCLES-1: on the next edge, mx_ready<=1, mx_err<=1, mx_rdata<=0, state IDLE.
  - bus_ack and timeout in the same cycle: the ack wins, err=0.
- Latency:
  - Request sampled in IDLE at cycle 0; bus active in cycles 1..k, where cycle k is the bus_ack cycle.
  - mx_ready high in cycle k+1.
  - Earliest next grant decision is in cycle k+1, with the bus active in k+2. Back-to-back throughput is one access per (ack latency + 1) cycles.
- Request changes mid-transaction: input changes are ignored after the grant. The transaction completes with the latched values.
- Request withdrawn: if a master withdraws its request mid-transaction, it still receives its ready pulse.
- bus_ack outside BUSY is ignored. mx_rdata and mx_err hold their value until the next completion of that master.
- Reset asserted mid-transaction:
  - Bus strobes drop immediately (asynchronous); state returns to IDLE.
  - No ready pulse is issued; the slave must tolerate the abandoned access.
- Counter width is clog2(TIMEOUT_CYCLES)+1 bits. It saturates, never wraps.

Test Plan:
- m0_req=1, m0_addr=0x0000_0100; slave acks in 2nd bus cycle with rdata=0x0051_3093 -> bus_re=1 and bus_addr=0x100 in cycles 1-2; m0_ready=1 in cycle 3 with m0_rdata=0x0051_3093, m0_err=0.
- m1_we=4'b0011, m1_addr=0x2000_0004, m1_wdata=0xDEAD_BEEF, immediate ack -> bus_we=0011, bus_re=0, bus_wdata=0xDEADBEEF for exactly one cycle; m1_ready pulse one cycle later with m1_rdata=0.
- Both requesting continuously from reset, slave acks after 1 cycle -> grant order M1, M0, M1, M0; no master is ever granted twice in a row.
- m1_re=1 and m1_we=4'b1111 together -> write issued, bus_re=0.
- m0_req held and slave never acks, TIMEOUT_CYCLES=4 -> bus held for exactly 4 cycles; then m0_ready=1, m0_err=1, m0_rdata=0; bus idle.
- rst pulsed while in BUSY_M1 with the bus active -> bus_re, bus_we, bus_addr go 0 during reset with no m1_ready. After release, a fresh m0_req is granted first because last_grant=M0 and only M0 requests.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Signal bundle joining the fetch master, the data master, the arbiter and the shared memory slave.
interface bus_arbiter_if;
   logic        m0_req;
   logic [31:0] m0_addr;
   logic        m0_ready;
   logic [31:0] m0_rdata;
   logic        m0_err;
   logic        m1_re;
   logic [3:0]  m1_we;
   logic [31:0] m1_addr;
   logic [31:0] m1_wdata;
   logic        m1_ready;
   logic [31:0] m1_rdata;
   logic        m1_err;
   logic        bus_re;
   logic [3:0]  bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   // Arbiter view: serves the masters' requests and drives the memory bus.
   modport slave (
      input  m0_req, m0_addr, m1_re, m1_we, m1_addr, m1_wdata, bus_rdata, bus_ack,
      output m0_ready, m0_rdata, m0_err, m1_ready, m1_rdata, m1_err,
      output bus_re, bus_we, bus_addr, bus_wdata
   );

   // Environment view: both masters plus the memory slave.
   modport master (
      output m0_req, m0_addr, m1_re, m1_we, m1_addr, m1_wdata, bus_rdata, bus_ack,
      input  m0_ready, m0_rdata, m0_err, m1_ready, m1_rdata, m1_err,
      input  bus_re, bus_we, bus_addr, bus_wdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the shared memory bus, with a per-access
// timeout that completes a hung access with an error flag.

module bus_arbiter_chk (
   input logic       clk,
   input logic       rst,
   input logic       bus_re,
   input logic [3:0] bus_we,
   input logic       m0_ready,
   input logic       m1_ready
);
   a_rw_exclusive : assert property (@(posedge clk) disable iff (rst)
      !(bus_re && (bus_we != 4'b0000)));
   a_single_ready : assert property (@(posedge clk) disable iff (rst)
      !(m0_ready && m1_ready));
   a_m0_pulse     : assert property (@(posedge clk) disable iff (rst)
      m0_ready |=> !m0_ready);
   a_m1_pulse     : assert property (@(posedge clk) disable iff (rst)
      m1_ready |=> !m1_ready);
   a_idle_on_done : assert property (@(posedge clk) disable iff (rst)
      (m0_ready || m1_ready) |-> (!bus_re && (bus_we == 4'b0000)));
endmodule

module bus_arbiter #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic         clk,
   input logic         rst,
   bus_arbiter_if.slave bif
);
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_M0 = 2'd1,
      BUSY_M1 = 2'd2
   } state_t;

   state_t      state_r;
   logic        last_grant_r;
   logic [CW-1:0] cnt_r;
   logic        bus_re_r;
   logic [3:0]  bus_we_r;
   logic [31:0] bus_addr_r;
   logic [31:0] bus_wdata_r;
   logic        m0_ready_r;
   logic [31:0] m0_rdata_r;
   logic        m0_err_r;
   logic        m1_ready_r;
   logic [31:0] m1_rdata_r;
   logic        m1_err_r;

   logic        m1_req_s;
   logic        m0_elig_s;
   logic        m1_elig_s;
   logic        any_grant_s;
   logic        grant_m1_s;
   logic        timeout_s;

   // Eligibility and round-robin choice; a master is not eligible in its own ready cycle.
   always_comb begin
      m1_req_s    = bif.m1_re | (|bif.m1_we);
      m0_elig_s   = bif.m0_req & ~m0_ready_r;
      m1_elig_s   = m1_req_s & ~m1_ready_r;
      any_grant_s = m0_elig_s | m1_elig_s;
      timeout_s   = (cnt_r == CNT_LAST);
      if (m0_elig_s && m1_elig_s) begin
         grant_m1_s = ~last_grant_r;
      end else begin
         grant_m1_s = m1_elig_s;
      end
   end

   // Arbitration FSM; the bus is driven purely from the latched request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= IDLE;
         last_grant_r <= 1'b0;
         cnt_r        <= CNT_ZERO;
         bus_re_r     <= 1'b0;
         bus_we_r     <= 4'b0000;
         bus_addr_r   <= 32'h0000_0000;
         bus_wdata_r  <= 32'h0000_0000;
         m0_ready_r   <= 1'b0;
         m0_rdata_r   <= 32'h0000_0000;
         m0_err_r     <= 1'b0;
         m1_ready_r   <= 1'b0;
         m1_rdata_r   <= 32'h0000_0000;
         m1_err_r     <= 1'b0;
      end else begin
         m0_ready_r <= 1'b0;
         m1_ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r <= CNT_ZERO;
               if (any_grant_s) begin
                  if (grant_m1_s) begin
                     // A combined read+write request is issued as a write only.
                     bus_re_r     <= bif.m1_re & ~(|bif.m1_we);
                     bus_we_r     <= bif.m1_we;
                     bus_addr_r   <= bif.m1_addr;
                     bus_wdata_r  <= bif.m1_wdata;
                     last_grant_r <= 1'b1;
                     state_r      <= BUSY_M1;
                  end else begin
                     bus_re_r     <= 1'b1;
                     bus_we_r     <= 4'b0000;
                     bus_addr_r   <= bif.m0_addr;
                     bus_wdata_r  <= 32'h0000_0000;
                     last_grant_r <= 1'b0;
                     state_r      <= BUSY_M0;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY_M0, BUSY_M1: begin
               if (cnt_r != CNT_MAX) begin
                  cnt_r <= cnt_r + CNT_ONE;
               end else begin
                  cnt_r <= cnt_r;
               end
               if (bif.bus_ack || timeout_s) begin
                  bus_re_r    <= 1'b0;
                  bus_we_r    <= 4'b0000;
                  bus_addr_r  <= 32'h0000_0000;
                  bus_wdata_r <= 32'h0000_0000;
                  state_r     <= IDLE;
                  if (state_r == BUSY_M0) begin
                     m0_ready_r <= 1'b1;
                     m0_err_r   <= ~bif.bus_ack;
                     m0_rdata_r <= bif.bus_ack ? bif.bus_rdata : 32'h0000_0000;
                  end else begin
                     m1_ready_r <= 1'b1;
                     m1_err_r   <= ~bif.bus_ack;
                     m1_rdata_r <= (bif.bus_ack && (bus_we_r == 4'b0000)) ?
                                   bif.bus_rdata : 32'h0000_0000;
                  end
               end else begin
                  state_r <= state_r;
               end
            end
            default: begin
               bus_re_r    <= 1'b0;
               bus_we_r    <= 4'b0000;
               bus_addr_r  <= 32'h0000_0000;
               bus_wdata_r <= 32'h0000_0000;
               state_r     <= IDLE;
            end
         endcase
      end
   end

   assign bif.bus_re    = bus_re_r;
   assign bif.bus_we    = bus_we_r;
   assign bif.bus_addr  = bus_addr_r;
   assign bif.bus_wdata = bus_wdata_r;
   assign bif.m0_ready  = m0_ready_r;
   assign bif.m0_rdata  = m0_rdata_r;
   assign bif.m0_err    = m0_err_r;
   assign bif.m1_ready  = m1_ready_r;
   assign bif.m1_rdata  = m1_rdata_r;
   assign bif.m1_err    = m1_err_r;

   bus_arbiter_chk u_chk (
      .clk      (clk),
      .rst      (rst),
      .bus_re   (bus_re_r),
      .bus_we   (bus_we_r),
      .m0_ready (m0_ready_r),
      .m1_ready (m1_ready_r)
   );
endmodule
